// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle between an SPI master front end and spi_sclk_gen.
// The master modport issues bursts; the slave modport is the clock generator.
interface spi_sclk_gen_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned BIT_W = 6
) ();
    logic             start;
    logic             abort;
    logic             cpol;
    logic             cpha;
    logic [CNT_W-1:0] div_half;
    logic [BIT_W-1:0] num_bits;
    logic             sclk;
    logic             busy;
    logic             done;
    logic             load_stb;
    logic             shift_stb;
    logic             sample_stb;
    logic [BIT_W-1:0] bit_idx;

    modport master (
        output start, abort, cpol, cpha, div_half, num_bits,
        input  sclk, busy, done, load_stb, shift_stb, sample_stb, bit_idx
    );

    modport slave (
        input  start, abort, cpol, cpha, div_half, num_bits,
        output sclk, busy, done, load_stb, shift_stb, sample_stb, bit_idx
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator and bit sequencer: divides clk_50 into SCLK for any
// CPOL/CPHA mode and emits load/shift/sample strobes for the data shift register.
module spi_sclk_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned BIT_W = 6
) (
    input logic           clk_50,
    input logic           rst_n,
    spi_sclk_gen_if.slave ctrl
);

    typedef enum logic [1:0] {StIdle, StRun, StTail} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;
    logic [BIT_W-1:0] nbits_q;
    logic [BIT_W-1:0] bit_idx_q;
    logic             cpol_q;
    logic             cpha_q;
    logic             sclk_q;
    logic             busy_q;
    logic             done_q;
    logic             load_q;
    logic             shift_q;
    logic             sample_q;

    logic [CNT_W-1:0] half_eff;
    logic [BIT_W-1:0] nbits_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;
    logic             lead_edge;
    logic             first_bit;
    logic             last_bit;

    always_comb begin
        half_eff  = (ctrl.div_half == '0) ? CNT_W'(1) : ctrl.div_half;
        nbits_eff = (ctrl.num_bits == '0) ? BIT_W'(1) : ctrl.num_bits;
        cnt_inc   = cnt_q + CNT_W'(1);
        cnt_hit   = (cnt_inc == half_q);
        // SCLK still at its idle level means the upcoming toggle is a lead edge.
        lead_edge = (sclk_q == cpol_q);
        first_bit = (bit_idx_q == '0);
        last_bit  = (bit_idx_q == nbits_q - BIT_W'(1));
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            half_q    <= CNT_W'(1);
            nbits_q   <= BIT_W'(1);
            bit_idx_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            sample_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sclk_q <= cpol_q;
                    if (ctrl.start && !ctrl.abort) begin
                        half_q    <= half_eff;
                        nbits_q   <= nbits_eff;
                        cpol_q    <= ctrl.cpol;
                        cpha_q    <= ctrl.cpha;
                        sclk_q    <= ctrl.cpol;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        busy_q    <= 1'b1;
                        load_q    <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (ctrl.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        sclk_q  <= cpol_q;
                    end else if (cnt_hit) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (lead_edge) begin
                            if (!cpha_q)        sample_q <= 1'b1;
                            else if (!first_bit) shift_q <= 1'b1;
                        end else begin
                            if (cpha_q)         sample_q <= 1'b1;
                            else if (!last_bit) shift_q  <= 1'b1;
                            if (!last_bit) bit_idx_q <= bit_idx_q + BIT_W'(1);
                            else           state_q   <= StTail;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StTail: begin
                    // Hold busy one extra half-period so CSN hold time is met.
                    if (ctrl.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt_hit) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctrl.sclk       = sclk_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.done       = done_q;
    assign ctrl.load_stb   = load_q;
    assign ctrl.shift_stb  = shift_q;
    assign ctrl.sample_stb = sample_q;
    assign ctrl.bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: directed bursts with a scoreboard of expected strobe events
// (relative cycle, kind, sclk, bit_idx) and busy lengths, compared as the DUT emits them.
module tb_spi_sclk_gen;
    localparam int CNT_W = 8;
    localparam int BIT_W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    spi_sclk_gen_if #(.CNT_W(CNT_W), .BIT_W(BIT_W)) bus_if ();

    spi_sclk_gen #(.CNT_W(CNT_W), .BIT_W(BIT_W)) dut (
        .clk_50 (clk),
        .rst_n  (rst_n),
        .ctrl   (bus_if)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          len_q[$];
    int          cyc = 0;
    int          base = 0;
    int          blen = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] obs_ev;
    logic [31:0] exp_ev;
    logic [3:0]  kind;
    int          req_len;

    // Event word: {relative cycle, {done,load,shift,sample}, sclk, pad, bit_idx}.
    function automatic logic [31:0] ev(int rel, logic [3:0] k, logic sck, int idx);
        return {16'(rel), k, sck, 5'b0, 6'(idx)};
    endfunction

    function automatic void push_burst(logic cpol, logic cpha, int div, int bits, int max_edges);
        int h, n, k, idx;
        logic lead, sck;
        logic [3:0] kd;
        h = (div == 0) ? 1 : div;
        n = (bits == 0) ? 1 : bits;
        exp_q.push_back(ev(0, 4'b0100, cpol, 0));
        for (int e = 1; e <= 2 * n && e <= max_edges; e++) begin
            lead = (e % 2) == 1;
            k    = (e - 1) / 2;
            sck  = lead ? ~cpol : cpol;
            idx  = lead ? k : ((k < n - 1) ? k + 1 : k);
            kd   = 4'b0000;
            if (!cpha) kd = lead ? 4'b0001 : ((k < n - 1) ? 4'b0010 : 4'b0000);
            else       kd = lead ? ((k > 0) ? 4'b0010 : 4'b0000) : 4'b0001;
            if (kd != 4'b0000) exp_q.push_back(ev(e * h, kd, sck, idx));
        end
        if (max_edges >= 2 * n) begin
            exp_q.push_back(ev((2 * n + 1) * h, 4'b1000, cpol, n - 1));
            len_q.push_back((2 * n + 1) * h);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_busy = 1'b0;
            blen      = 0;
        end else begin
            if (bus_if.busy && !prev_busy) base = cyc;
            kind = {bus_if.done, bus_if.load_stb, bus_if.shift_stb, bus_if.sample_stb};
            if (kind != 4'b0000) begin
                obs_ev = ev(cyc - base, kind, bus_if.sclk, int'(bus_if.bit_idx));
                exp_ev = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                vectors++;
                assert (obs_ev === exp_ev) else begin
                    miscompares++;
                    $error("FAIL strobe_event observed=%h required=%h", obs_ev, exp_ev);
                end
            end
            if (bus_if.busy) begin
                blen++;
            end else if (prev_busy) begin
                req_len = (len_q.size() != 0) ? len_q.pop_front() : -1;
                vectors++;
                assert (blen === req_len) else begin
                    miscompares++;
                    $error("FAIL busy_length observed=%0d required=%0d", blen, req_len);
                end
                blen = 0;
            end
            prev_busy = bus_if.busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    task automatic start_burst(logic cpol, logic cpha, int div, int bits, int max_edges);
        bus_if.cpol     = cpol;
        bus_if.cpha     = cpha;
        bus_if.div_half = CNT_W'(div);
        bus_if.num_bits = BIT_W'(bits);
        bus_if.start    = 1'b1;
        push_burst(cpol, cpha, div, bits, max_edges);
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(int limit);
        int n = 0;
        while (bus_if.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("done_seen", 32'(bus_if.done), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.cpol = 1'b0; bus_if.cpha = 1'b0;
        bus_if.div_half = '0; bus_if.num_bits = '0;
        repeat (3) tick();
        check("rst_sclk", 32'(bus_if.sclk), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_idx", 32'(bus_if.bit_idx), 32'd0);
        check("rst_strobes", 32'({bus_if.done, bus_if.load_stb, bus_if.shift_stb,
                                  bus_if.sample_stb}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Mode 0, H=5, N=8.
        start_burst(1'b0, 1'b0, 5, 8, 99);
        wait_done(200);
        repeat (3) tick();
        check("t1_idle_sclk", 32'(bus_if.sclk), 32'd0);
        check("t1_events_left", 32'(exp_q.size()), 32'd0);

        // Mode 3, H=1, N=4.
        start_burst(1'b1, 1'b1, 1, 4, 99);
        wait_done(50);
        repeat (3) tick();
        check("t2_idle_sclk", 32'(bus_if.sclk), 32'd1);
        check("t2_events_left", 32'(exp_q.size()), 32'd0);

        // Zero divider and bit count.
        start_burst(1'b0, 1'b0, 0, 0, 99);
        wait_done(50);
        repeat (3) tick();
        check("t3_events_left", 32'(exp_q.size()), 32'd0);

        // Mid-burst changes ignored; start in done cycle chains a second burst.
        start_burst(1'b0, 1'b0, 3, 3, 99);
        repeat (4) tick();
        bus_if.start = 1'b1; bus_if.cpol = 1'b1; bus_if.cpha = 1'b1;
        bus_if.div_half = 8'd7; bus_if.num_bits = 6'd9;
        tick();
        bus_if.start = 1'b0;
        wait_done(100);
        start_burst(1'b1, 1'b0, 2, 2, 99);
        check("t4_b2b_busy", 32'(bus_if.busy), 32'd1);
        wait_done(100);
        repeat (3) tick();
        check("t4_events_left", 32'(exp_q.size()), 32'd0);

        // Abort right after the 3rd edge (H=2 -> edge 3 at relative cycle 6).
        start_burst(1'b0, 1'b1, 2, 4, 3);
        len_q.push_back(7);
        repeat (6) tick();
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check("t5_abort_busy", 32'(bus_if.busy), 32'd0);
        check("t5_abort_sclk", 32'(bus_if.sclk), 32'd0);
        check("t5_abort_done", 32'(bus_if.done), 32'd0);
        repeat (12) tick();
        check("t5_events_left", 32'(exp_q.size()), 32'd0);
        bus_if.start = 1'b1; bus_if.abort = 1'b1;
        tick();
        bus_if.start = 1'b0; bus_if.abort = 1'b0;
        repeat (3) tick();
        check("t5_start_abort_busy", 32'(bus_if.busy), 32'd0);

        // Reset mid-burst with cpol=1, then a fresh burst.
        start_burst(1'b1, 1'b0, 4, 8, 99);
        repeat (10) tick();
        rst_n = 1'b0;
        exp_q.delete();
        len_q.delete();
        tick();
        check("t6_rst_sclk", 32'(bus_if.sclk), 32'd0);
        check("t6_rst_busy", 32'(bus_if.busy), 32'd0);
        check("t6_rst_idx", 32'(bus_if.bit_idx), 32'd0);
        check("t6_rst_strobes", 32'({bus_if.done, bus_if.load_stb, bus_if.shift_stb,
                                     bus_if.sample_stb}), 32'd0);
        rst_n = 1'b1;
        tick();
        start_burst(1'b0, 1'b1, 2, 2, 99);
        wait_done(100);
        repeat (3) tick();
        check("t6_events_left", 32'(exp_q.size()), 32'd0);
        check("t6_lengths_left", 32'(len_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
